// File: rtl/sr_latch.sv
// sr_latch -- clocked set/reset storage element with a defined S=R=1 response.
//
// Behaves like an SR latch whose inputs are sampled on the rising edge of clk.
// Unlike an unclocked NOR latch, Q and Qn are always complementary, and the
// S=R=1 case is resolved by the BOTH_POLICY parameter rather than producing
// the illegal both-low output.
//
// Parameters
//   BOTH_POLICY  S=R=1 response: 0 = hold, 1 = reset-dominant (default),
//                2 = set-dominant; any other value is treated as 1.
//
// Ports
//   clk      in   rising-edge clock for all state
//   rst_n    in   synchronous active-low reset (Q=0, Qn=1, flags cleared)
//   S        in   set request, sampled on the rising edge of clk
//   R        in   reset request, sampled on the rising edge of clk
//   Q        out  stored state, registered
//   Qn       out  complement of Q, registered
//   invalid  out  high for the cycle after an edge that sampled S=R=1
//   changed  out  high for the cycle after an edge where Q changed value
//
// State  | meaning
// -------+--------------------------------
// ST_CLR | stored value 0 (Q=0, Qn=1)
// ST_SET | stored value 1 (Q=1, Qn=0)

module sr_latch #(
    parameter int BOTH_POLICY = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic S,
    input  logic R,
    output logic Q,
    output logic Qn,
    output logic invalid,
    output logic changed
);

    // Out-of-range policy values collapse to reset-dominant.
    localparam int POLICY = ((BOTH_POLICY == 0) || (BOTH_POLICY == 2)) ? BOTH_POLICY : 1;

    typedef enum logic {
        ST_CLR = 1'b0,
        ST_SET = 1'b1
    } state_t;

    state_t state;
    state_t state_next;
    logic   qn_reg;
    logic   invalid_reg;
    logic   changed_reg;

    // State register. Qn gets its own flop, loaded with the complement of the
    // next state, so both outputs come straight from registers and can never
    // be equal.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_CLR;
            qn_reg      <= 1'b1;
            invalid_reg <= 1'b0;
            changed_reg <= 1'b0;
        end else begin
            state       <= state_next;
            qn_reg      <= ~state_next;
            invalid_reg <= S & R;
            changed_reg <= (state_next != state);
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case ({S, R})
            2'b10: state_next = ST_SET;
            2'b01: state_next = ST_CLR;
            2'b11: begin
                if (POLICY == 0) begin
                    state_next = state;
                end else if (POLICY == 2) begin
                    state_next = ST_SET;
                end else begin
                    state_next = ST_CLR;
                end
            end
            default: state_next = state;
        endcase
    end

    // Output logic.
    always_comb begin
        Q       = (state == ST_SET);
        Qn      = qn_reg;
        invalid = invalid_reg;
        changed = changed_reg;
    end

endmodule

// File: tb/tb_sr_latch.sv
// Directed bench for sr_latch. Four instances share clk/rst_n/S/R and differ
// only in BOTH_POLICY (0, 1, 2 and an out-of-range 3 that must act like 1).
module tb_sr_latch;

    logic clk;
    logic rst_n;
    logic s;
    logic r;
    logic q   [4];
    logic qn  [4];
    logic inv [4];
    logic chg [4];

    int tests_run;
    int tests_failed;

    sr_latch #(.BOTH_POLICY(0)) u_p0 (
        .clk(clk), .rst_n(rst_n), .S(s), .R(r),
        .Q(q[0]), .Qn(qn[0]), .invalid(inv[0]), .changed(chg[0])
    );
    sr_latch #(.BOTH_POLICY(1)) u_p1 (
        .clk(clk), .rst_n(rst_n), .S(s), .R(r),
        .Q(q[1]), .Qn(qn[1]), .invalid(inv[1]), .changed(chg[1])
    );
    sr_latch #(.BOTH_POLICY(2)) u_p2 (
        .clk(clk), .rst_n(rst_n), .S(s), .R(r),
        .Q(q[2]), .Qn(qn[2]), .invalid(inv[2]), .changed(chg[2])
    );
    sr_latch #(.BOTH_POLICY(3)) u_p3 (
        .clk(clk), .rst_n(rst_n), .S(s), .R(r),
        .Q(q[3]), .Qn(qn[3]), .invalid(inv[3]), .changed(chg[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (obs !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive inputs on the falling edge, then sample just after the rising edge.
    task automatic step(input logic rn, input logic sv, input logic rv);
        @(negedge clk);
        rst_n = rn;
        s     = sv;
        r     = rv;
        @(posedge clk);
        #1;
    endtask

    // Check all four outputs of one instance.
    task automatic check_all(input string tag, input int i,
                             input logic eq, input logic einv, input logic echg);
        check_eq({tag, ".Q"},       {31'd0, q[i]},   {31'd0, eq});
        check_eq({tag, ".Qn"},      {31'd0, qn[i]},  {31'd0, ~eq});
        check_eq({tag, ".invalid"}, {31'd0, inv[i]}, {31'd0, einv});
        check_eq({tag, ".changed"}, {31'd0, chg[i]}, {31'd0, echg});
    endtask

    logic [1:0] seq_sr [5];
    logic       seq_q  [5];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        s     = 1'b1;
        r     = 1'b0;

        // Reset with S=1 held: reset wins.
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) check_all($sformatf("rst_p%0d", i), i, 1'b0, 1'b0, 1'b0);

        // First edge after release applies the set.
        step(1'b1, 1'b1, 1'b0);
        check_all("first_set", 1, 1'b1, 1'b0, 1'b1);

        step(1'b1, 1'b0, 1'b0);
        check_all("hold_1", 1, 1'b1, 1'b0, 1'b0);

        step(1'b1, 1'b0, 1'b1);
        check_all("reset_from_1", 1, 1'b0, 1'b0, 1'b1);

        step(1'b1, 1'b0, 1'b0);
        check_all("hold_0", 1, 1'b0, 1'b0, 1'b0);

        // S=R=1 from Q=1 under every policy.
        step(1'b1, 1'b1, 1'b0);
        check_all("set_again", 1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check_all("both_p0_from1", 0, 1'b1, 1'b1, 1'b0);
        check_all("both_p1_from1", 1, 1'b0, 1'b1, 1'b1);
        check_all("both_p2_from1", 2, 1'b1, 1'b1, 1'b0);
        check_all("both_p3_from1", 3, 1'b0, 1'b1, 1'b1);

        // Consecutive S=R=1 keeps invalid high.
        step(1'b1, 1'b1, 1'b1);
        check_all("both2_p1", 1, 1'b0, 1'b1, 1'b0);
        check_all("both2_p0", 0, 1'b1, 1'b1, 1'b0);

        step(1'b1, 1'b1, 1'b0);
        check_all("set_after_both", 1, 1'b1, 1'b0, 1'b1);

        // S=R=1 from Q=0.
        step(1'b1, 1'b0, 1'b1);
        check_all("clr_p2", 2, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check_all("both_p0_from0", 0, 1'b0, 1'b1, 1'b0);
        check_all("both_p1_from0", 1, 1'b0, 1'b1, 1'b0);
        check_all("both_p2_from0", 2, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        check_all("idle_p2", 2, 1'b1, 1'b0, 1'b0);

        // set, reset, both, set, reset on the reset-dominant instance.
        seq_sr[0] = 2'b10; seq_q[0] = 1'b1;
        seq_sr[1] = 2'b01; seq_q[1] = 1'b0;
        seq_sr[2] = 2'b11; seq_q[2] = 1'b0;
        seq_sr[3] = 2'b10; seq_q[3] = 1'b1;
        seq_sr[4] = 2'b01; seq_q[4] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, seq_sr[k][1], seq_sr[k][0]);
            check_eq($sformatf("seq%0d.Q", k),  {31'd0, q[1]},  {31'd0, seq_q[k]});
            check_eq($sformatf("seq%0d.Qn", k), {31'd0, qn[1]}, {31'd0, ~seq_q[k]});
            check_eq($sformatf("seq%0d.invalid", k), {31'd0, inv[1]},
                     {31'd0, (seq_sr[k] == 2'b11)});
        end

        // Glitch on S between edges must not be captured (Q is 0 here).
        #2 s = 1'b1;
        #2 s = 1'b0;
        @(posedge clk);
        #1;
        check_all("glitch_p1", 1, 1'b0, 1'b0, 1'b0);
        check_all("glitch_p2", 2, 1'b0, 1'b0, 1'b0);

        // Mid-operation reset from Q=1, with S=R=1 present on the reset edge.
        step(1'b1, 1'b1, 1'b0);
        check_all("pre_rst_set", 1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) check_all($sformatf("midrst_p%0d", i), i, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check_all("release_idle", 1, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sr_latch.md
SR_LATCH -- requirements
Module: sr_latch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter BOTH_POLICY SHALL default to 1 and select the S=R=1 response: 0 = hold, 1 = reset-dominant, 2 = set-dominant; any other value SHALL behave as 1.
REQ-003 Port clk SHALL be an input, 1 bit, the rising-edge clock for all state.
REQ-004 Port rst_n SHALL be an input, 1 bit, the synchronous active-low reset.
REQ-005 Port S SHALL be an input, 1 bit, the set request, sampled on the rising edge of clk.
REQ-006 Port R SHALL be an input, 1 bit, the reset request, sampled on the rising edge of clk.
REQ-007 Port Q SHALL be an output, 1 bit, the stored state, registered.
REQ-008 Port Qn SHALL be an output, 1 bit, the complement of Q, registered.
REQ-009 Port invalid SHALL be an output, 1 bit, high for one cycle after S=R=1 is sampled.
REQ-010 Port changed SHALL be an output, 1 bit, high for one cycle after Q toggles.

Function
REQ-011 At each rising clk edge with rst_n=1, S=1 and R=0 SHALL set Q to 1.
REQ-012 At each rising clk edge with rst_n=1, S=0 and R=1 SHALL set Q to 0.
REQ-013 At each rising clk edge with rst_n=1, S=0 and R=0 SHALL hold Q unchanged.
REQ-014 S=1 and R=1 SHALL apply BOTH_POLICY:
- hold: Q unchanged
- reset-dominant: Q becomes 0
- set-dominant: Q becomes 1
REQ-015 Qn SHALL equal the complement of Q in every cycle, including after S=R=1; the both-zero output state of an unclocked NOR latch SHALL NOT occur.
REQ-016 Latency SHALL be one clock: the new Q/Qn value SHALL be visible immediately after the edge that samples S/R.
REQ-017 Q and Qn SHALL change only on rising clk edges; changes of S/R between edges SHALL have no effect.
REQ-018 invalid SHALL be registered and SHALL be 1 in the cycle after an edge that sampled S=R=1, otherwise 0; it SHALL be 1 for every cycle of consecutive S=R=1 samples.
REQ-019 changed SHALL be registered and SHALL be 1 in the cycle after an edge where Q took a value different from its previous value, otherwise 0.
REQ-020 An S=R=1 sample SHALL update Q per BOTH_POLICY in the same edge that raises invalid.
REQ-021 No output SHALL ever be X or Z after the first reset.

Reset
REQ-022 While rst_n=0 at a rising clk edge, the edge SHALL drive Q=0, Qn=1, invalid=0 and changed=0, regardless of S and R.
REQ-023 Reset SHALL take priority over S and R on the same edge.
REQ-024 Reset deassertion SHALL NOT produce a changed pulse.
REQ-025 The first edge with rst_n=1 SHALL apply normal S/R behaviour.
REQ-026 A reset applied mid-operation from Q=1 SHALL clear Q on that edge and leave changed=0 after it.

Verification
REQ-027 Reset with S=1 and R=0 held SHALL give Q=0, Qn=1, invalid=0 and changed=0 after the edge. After release, S=1, R=0 for one edge SHALL give Q=1, Qn=0 and changed=1.
REQ-028 From Q=1, S=0, R=1 for one edge SHALL give Q=0, Qn=1 and changed=1. A further edge with S=0, R=0 SHALL give Q=0 and changed=0.
REQ-029 From Q=1 with BOTH_POLICY=1, S=1, R=1 SHALL give Q=0, Qn=1, invalid=1 and changed=1. The next edge with S=1, R=0 SHALL give Q=1, Qn=0 and invalid=0.
REQ-030 S=R=1 SHALL be exercised under each policy:
- BOTH_POLICY=0 from Q=1: Q stays 1, invalid=1, changed=0
- BOTH_POLICY=2 from Q=0: Q becomes 1, invalid=1
REQ-031 Sequence set, reset, both, set, reset (one edge each, BOTH_POLICY=1) SHALL give Q = 1, 0, 0, 1, 0, with Qn = ~Q at every sample.
REQ-032 A pulse on S=1 between clock edges, deasserted before the next edge, SHALL leave Q unchanged.
